// File: rtl/nano_lsu_hs.sv
// Handshaked load/store unit: sizes and aligns stores, extends loads, stalls the core until
// memory acks, and flags misaligned/illegal accesses and access timeouts.
module nano_lsu_hs #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [2:0]        funct3_i,
    input  logic [XLEN-1:0]   addr_i,
    input  logic [XLEN-1:0]   wdata_i,
    output logic              stall_o,
    output logic [XLEN-1:0]   rdata_o,
    output logic              rdata_valid_o,
    output logic              err_o,
    output logic [XLEN-1:0]   d_addr_o,
    output logic [XLEN-1:0]   d_data_o,
    output logic              d_rd_o,
    output logic              d_wr_o,
    output logic [XLEN/8-1:0] d_we_o,
    input  logic [XLEN-1:0]   d_data_i,
    input  logic              d_ack_i
);

    localparam int unsigned NB       = XLEN / 8;
    localparam int unsigned LaneW    = $clog2(NB);
    localparam int unsigned CntW     = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
    localparam int unsigned WaitLast = (MAX_WAIT == 0) ? 0 : MAX_WAIT - 1;

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   addr_q, wdata_q, rdata_q;
    logic [2:0]        funct3_q;
    logic              we_q, err_q;
    logic [CntW-1:0]   cnt_q;

    logic              misaligned, size_ok, legal, timeout;
    logic [LaneW-1:0]  lane_q;
    logic [XLEN-1:0]   shifted, load_ext, store_rep;
    logic [NB-1:0]     be_base, be;

    assign lane_q  = addr_q[LaneW-1:0];
    assign timeout = (MAX_WAIT != 0) && (cnt_q == CntW'(WaitLast));
    assign rdata_o = rdata_q;

    always_comb begin
        misaligned = 1'b0;
        unique case (funct3_i[1:0])
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = addr_i[0];
            2'b10:   misaligned = |addr_i[1:0];
            default: misaligned = |addr_i[2:0];
        endcase
        if (we_i) begin
            size_ok = !funct3_i[2] && ((funct3_i[1:0] != 2'b11) || (XLEN == 64));
        end else begin
            size_ok = (funct3_i != 3'b111) &&
                      (((funct3_i != 3'b011) && (funct3_i != 3'b110)) || (XLEN == 64));
        end
        legal = size_ok && !misaligned;
    end

    // Move the addressed lane down to bit 0, then extend by access size.
    always_comb begin
        shifted  = d_data_i >> {lane_q, 3'b000};
        load_ext = shifted;
        case (funct3_q)
            3'b000:  load_ext = XLEN'($signed(shifted[7:0]));
            3'b001:  load_ext = XLEN'($signed(shifted[15:0]));
            3'b010:  load_ext = XLEN'($signed(shifted[31:0]));
            3'b100:  load_ext = XLEN'(shifted[7:0]);
            3'b101:  load_ext = XLEN'(shifted[15:0]);
            3'b110:  load_ext = XLEN'(shifted[31:0]);
            default: load_ext = shifted;
        endcase
    end

    always_comb begin
        be_base   = '1;
        store_rep = wdata_q;
        unique case (funct3_q[1:0])
            2'b00: begin
                be_base   = NB'(1);
                store_rep = {NB{wdata_q[7:0]}};
            end
            2'b01: begin
                be_base   = NB'(3);
                store_rep = {(NB / 2){wdata_q[15:0]}};
            end
            2'b10: begin
                be_base   = NB'(4'hF);
                store_rep = {(NB / 4){wdata_q[31:0]}};
            end
            default: begin
                be_base   = '1;
                store_rep = wdata_q;
            end
        endcase
        be = be_base << lane_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= StIdle;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (req_i) state_d = legal ? StAccess : StDone;
            StAccess: if (d_ack_i || timeout) state_d = StDone;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            funct3_q <= '0;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else if (state_q == StIdle && req_i) begin
            addr_q   <= addr_i;
            wdata_q  <= wdata_i;
            funct3_q <= funct3_i;
            we_q     <= we_i;
            err_q    <= !legal;
            cnt_q    <= '0;
        end else if (state_q == StAccess) begin
            // Ack beats a timeout landing in the same cycle.
            if (d_ack_i) begin
                if (!we_q) rdata_q <= load_ext;
            end else if (timeout) begin
                err_q <= 1'b1;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        stall_o       = (state_q == StIdle && req_i) || (state_q == StAccess);
        d_rd_o        = 1'b0;
        d_wr_o        = 1'b0;
        d_addr_o      = '0;
        d_data_o      = '0;
        d_we_o        = '0;
        rdata_valid_o = 1'b0;
        err_o         = 1'b0;
        if (state_q == StAccess) begin
            d_rd_o   = !we_q;
            d_wr_o   = we_q;
            d_addr_o = {addr_q[XLEN-1:LaneW], {LaneW{1'b0}}};
            if (we_q) begin
                d_we_o   = be;
                d_data_o = store_rep;
            end
        end
        if (state_q == StDone) begin
            rdata_valid_o = !err_q && !we_q;
            err_o         = err_q;
        end
    end

endmodule

// File: tb/tb_nano_lsu_hs.sv
// Directed bench for nano_lsu_hs (XLEN=32, MAX_WAIT=4) with hand-computed expectations.
module tb_nano_lsu_hs;

    logic        clk = 1'b0;
    logic        rst_i, req_i, we_i, d_ack_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i, wdata_i, d_data_i;
    logic        stall_o, rdata_valid_o, err_o, d_rd_o, d_wr_o;
    logic [31:0] rdata_o, d_addr_o, d_data_o;
    logic [3:0]  d_we_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    nano_lsu_hs #(.XLEN(32), .MAX_WAIT(4)) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .req_i         (req_i),
        .we_i          (we_i),
        .funct3_i      (funct3_i),
        .addr_i        (addr_i),
        .wdata_i       (wdata_i),
        .stall_o       (stall_o),
        .rdata_o       (rdata_o),
        .rdata_valid_o (rdata_valid_o),
        .err_o         (err_o),
        .d_addr_o      (d_addr_o),
        .d_data_o      (d_data_o),
        .d_rd_o        (d_rd_o),
        .d_wr_o        (d_wr_o),
        .d_we_o        (d_we_o),
        .d_data_i      (d_data_i),
        .d_ack_i       (d_ack_i)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One transaction: request in cycle 0, ack in access cycle ack_at (0 = never).
    // Runs until the first cycle with stall low, then samples one more cycle.
    task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] din, input int ack_at,
                          output int n_stall, output int n_rd, output int n_wr,
                          output logic err, output logic valid, output logic [31:0] rdata,
                          output logic [31:0] s_addr, output logic [31:0] s_data,
                          output logic [3:0] s_we, output logic post_flag);
        bit done = 0;
        n_stall = 0; n_rd = 0; n_wr = 0;
        err = 0; valid = 0; rdata = '0; s_addr = '0; s_data = '0; s_we = '0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            req_i    = (k == 0);
            we_i     = we;
            funct3_i = f3;
            addr_i   = addr;
            wdata_i  = wdata;
            d_data_i = din;
            d_ack_i  = (k != 0) && (k == ack_at);
            #1;
            if (stall_o) n_stall++;
            if (d_rd_o)  n_rd++;
            if (d_wr_o)  n_wr++;
            if (d_rd_o || d_wr_o) begin
                s_addr = d_addr_o;
                s_data = d_data_o;
                s_we   = d_we_o;
            end
            if (!stall_o) begin
                done  = 1;
                err   = err_o;
                valid = rdata_valid_o;
                rdata = rdata_o;
            end
        end
        @(negedge clk);
        req_i   = 0;
        d_ack_i = 0;
        #1;
        post_flag = err_o | rdata_valid_o | stall_o;
        if (!done) check("op_completes", 32'd0, 32'd1);
    endtask

    int          ns, nr, nw;
    logic        e, v, pf;
    logic [31:0] rd, sa, sd;
    logic [3:0]  sw;

    initial begin
        rst_i = 1; req_i = 0; we_i = 0; funct3_i = 0; addr_i = 0; wdata_i = 0;
        d_data_i = 0; d_ack_i = 0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_stall", {31'd0, stall_o}, 0);
        check("rst_strobes", {30'd0, d_rd_o, d_wr_o}, 0);
        check("rst_valid_err", {30'd0, rdata_valid_o, err_o}, 0);
        check("rst_rdata", rdata_o, 0);
        check("rst_daddr", d_addr_o, 0);
        check("rst_dwe", {28'd0, d_we_o}, 0);
        @(negedge clk);
        rst_i = 0;

        // LW, ack in first access cycle
        run_op(0, 3'b010, 32'h100, 0, 32'h12345678, 1, ns, nr, nw, e, v, rd, sa, sd, sw, pf);
        check("lw_stall", ns, 2);
        check("lw_rd", nr, 1);
        check("lw_addr", sa, 32'h100);
        check("lw_valid", {31'd0, v}, 1);
        check("lw_err", {31'd0, e}, 0);
        check("lw_rdata", rd, 32'h12345678);
        check("lw_pulse", {31'd0, pf}, 0);
        check("lw_hold", rdata_o, 32'h12345678);

        // LB / LBU from lane 3
        run_op(0, 3'b000, 32'h103, 0, 32'h80AABBCC, 1, ns, nr, nw, e, v, rd, sa, sd, sw, pf);
        check("lb_rdata", rd, 32'hFFFFFF80);
        check("lb_addr", sa, 32'h100);
        run_op(0, 3'b100, 32'h103, 0, 32'h80AABBCC, 1, ns, nr, nw, e, v, rd, sa, sd, sw, pf);
        check("lbu_rdata", rd, 32'h00000080);

        // LH / LHU from upper half
        run_op(0, 3'b001, 32'h202, 0, 32'h8001_1234, 1, ns, nr, nw, e, v, rd, sa, sd, sw, pf);
        check("lh_rdata", rd, 32'hFFFF8001);
        run_op(0, 3'b101, 32'h202, 0, 32'h8001_1234, 1, ns, nr, nw, e, v, rd, sa, sd, sw, pf);
        check("lhu_rdata", rd, 32'h00008001);

        // SH, ack on second access cycle
        run_op(1, 3'b001, 32'h102, 32'h0000BEEF, 0, 2, ns, nr, nw, e, v, rd, sa, sd, sw, pf);
        check("sh_addr", sa, 32'h100);
        check("sh_we", {28'd0, sw}, 32'hC);
        check("sh_data", sd, 32'hBEEFBEEF);
        check("sh_wr", nw, 2);
        check("sh_rd", nr, 0);
        check("sh_valid", {31'd0, v}, 0);
        check("sh_rdata_hold", rd, 32'h00008001);

        // SB lane 1, SW lane 0
        run_op(1, 3'b000, 32'h101, 32'h123456A5, 0, 1, ns, nr, nw, e, v, rd, sa, sd, sw, pf);
        check("sb_we", {28'd0, sw}, 32'h2);
        check("sb_data", sd, 32'hA5A5A5A5);
        run_op(1, 3'b010, 32'h104, 32'hCAFEF00D, 0, 1, ns, nr, nw, e, v, rd, sa, sd, sw, pf);
        check("sw_we", {28'd0, sw}, 32'hF);
        check("sw_data", sd, 32'hCAFEF00D);
        check("sw_addr", sa, 32'h104);

        // Misaligned LW
        run_op(0, 3'b010, 32'h1001, 0, 0, 0, ns, nr, nw, e, v, rd, sa, sd, sw, pf);
        check("mis_rd", nr, 0);
        check("mis_stall", ns, 1);
        check("mis_err", {31'd0, e}, 1);
        check("mis_valid", {31'd0, v}, 0);
        check("mis_pulse", {31'd0, pf}, 0);

        // LD and store funct3=100 are illegal at XLEN=32
        run_op(0, 3'b011, 32'h100, 0, 0, 0, ns, nr, nw, e, v, rd, sa, sd, sw, pf);
        check("ld32_err", {31'd0, e}, 1);
        check("ld32_rd", nr, 0);
        run_op(1, 3'b100, 32'h100, 0, 0, 0, ns, nr, nw, e, v, rd, sa, sd, sw, pf);
        check("st100_err", {31'd0, e}, 1);
        check("st100_wr", nw, 0);

        // Timeout at MAX_WAIT=4
        run_op(0, 3'b010, 32'h300, 0, 32'h55AA55AA, 0, ns, nr, nw, e, v, rd, sa, sd, sw, pf);
        check("to_rd", nr, 4);
        check("to_stall", ns, 5);
        check("to_err", {31'd0, e}, 1);
        check("to_valid", {31'd0, v}, 0);
        // Ack on the would-be timeout cycle succeeds
        run_op(0, 3'b010, 32'h300, 0, 32'h55AA55AA, 4, ns, nr, nw, e, v, rd, sa, sd, sw, pf);
        check("to_ack_rd", nr, 4);
        check("to_ack_err", {31'd0, e}, 0);
        check("to_ack_valid", {31'd0, v}, 1);
        check("to_ack_rdata", rd, 32'h55AA55AA);

        // Reset during ACCESS
        @(negedge clk);
        req_i = 1; we_i = 0; funct3_i = 3'b010; addr_i = 32'h400; d_ack_i = 0;
        @(negedge clk);
        req_i = 0;
        #1;
        check("abort_rd_before", {31'd0, d_rd_o}, 1);
        @(negedge clk);
        rst_i = 1;
        @(negedge clk);
        rst_i = 0;
        #1;
        check("abort_rd", {31'd0, d_rd_o}, 0);
        check("abort_stall", {31'd0, stall_o}, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            check("abort_quiet", {30'd0, err_o, rdata_valid_o}, 0);
        end
        run_op(0, 3'b010, 32'h400, 0, 32'hDEADBEEF, 1, ns, nr, nw, e, v, rd, sa, sd, sw, pf);
        check("post_rst_stall", ns, 2);
        check("post_rst_valid", {31'd0, v}, 1);
        check("post_rst_rdata", rd, 32'hDEADBEEF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
